// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// mem_loader : framed byte-stream loader driving the write port of a DEPTH x 8 RAM
// Revision   : 1.0
// ============================================================================
module mem_loader #(
    parameter int         DEPTH          = 1024,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    localparam int        AW             = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clka,
    input  logic          rsta,
    input  logic [7:0]    s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          error
);

    localparam int            TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_H,
        ST_ADDR_L,
        ST_LEN_H,
        ST_LEN_L,
        ST_DATA,
        ST_CSUM
    } state_t;

    state_t        state_q,   state_d;
    logic [7:0]    addr_hi_q, addr_hi_d;
    logic [AW-1:0] addr_q,    addr_d;
    logic [15:0]   len_q,     len_d;
    logic [7:0]    sum_q,     sum_d;
    logic [TW-1:0] tmo_q,     tmo_d;
    logic          wr_en_q,   wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          done_q,    done_d;
    logic          error_q,   error_d;

    logic          accept;
    logic [7:0]    sum_next;
    logic [15:0]   len_full;
    logic          tmo_hit;

    assign s_ready  = ~rsta;
    assign accept   = s_valid & s_ready;
    assign sum_next = sum_q + s_data;
    assign len_full = {len_q[15:8], s_data};
    // An accepted byte in the expiry cycle takes priority over the timeout.
    assign tmo_hit  = (state_q != ST_IDLE) && !accept && (tmo_q == TMO_LAST);

    always_comb begin
        state_d   = state_q;
        addr_hi_d = addr_hi_q;
        addr_d    = addr_q;
        len_d     = len_q;
        sum_d     = sum_q;
        tmo_d     = tmo_q + 1'b1;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        if (accept || (state_q == ST_IDLE)) begin
            tmo_d = '0;
        end

        if (accept) begin
            sum_d = sum_next;
            case (state_q)
                ST_IDLE: begin
                    sum_d = 8'd0;
                    if (s_data == SYNC_BYTE) begin
                        state_d = ST_ADDR_H;
                    end
                end
                ST_ADDR_H: begin
                    addr_hi_d = s_data;
                    state_d   = ST_ADDR_L;
                end
                ST_ADDR_L: begin
                    // Upper address bits beyond the RAM depth are dropped.
                    addr_d  = AW'({addr_hi_q, s_data});
                    state_d = ST_LEN_H;
                end
                ST_LEN_H: begin
                    len_d   = {s_data, 8'h00};
                    state_d = ST_LEN_L;
                end
                ST_LEN_L: begin
                    len_d   = len_full;
                    state_d = (len_full == 16'd0) ? ST_CSUM : ST_DATA;
                end
                ST_DATA: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = s_data;
                    addr_d    = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
                    len_d     = len_q - 1'b1;
                    if (len_q == 16'd1) begin
                        state_d = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    state_d = ST_IDLE;
                    if (sum_next == 8'd0) begin
                        done_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (tmo_hit) begin
            error_d = 1'b1;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state_q   <= ST_IDLE;
            addr_hi_q <= 8'd0;
            addr_q    <= '0;
            len_q     <= 16'd0;
            sum_q     <= 8'd0;
            tmo_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'd0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_hi_q <= addr_hi_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            sum_q     <= sum_d;
            tmo_q     <= tmo_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign done     = done_q;
    assign error    = error_q;
    // The frame ends in the same cycle that done/error pulses, since the FSM is already IDLE then.
    assign busy     = (state_q != ST_IDLE);
    assign cpu_hold = busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
// tb_mem_loader : scoreboard bench for mem_loader (DEPTH=1024, TIMEOUT_CYCLES=16).
module tb_mem_loader;

    localparam int         DEPTH = 1024;
    localparam int         TMO   = 16;
    localparam logic [7:0] SYNC  = 8'hA5;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic [7:0] s_data  = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_ready, wr_en, cpu_hold, busy, done, error;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct { logic [9:0] addr; logic [7:0] data; int at; } wr_t;
    typedef struct { bit err; int at; } ev_t;
    wr_t wq[$];
    ev_t eq[$];
    logic [7:0] pl [0:255];

    mem_loader #(
        .DEPTH          (DEPTH),
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clka     (clk),
        .rsta     (rst),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : mon
        wr_t w;
        ev_t e;
        if (wq.size() != 0 && wq[0].at == cyc) begin
            w = wq.pop_front();
            check("wr_en", wr_en, 1);
            check("wr_addr", wr_addr, w.addr);
            check("wr_data", wr_data, w.data);
        end else if (wr_en) begin
            check("wr_unexpected", wr_en, 0);
        end
        if (eq.size() != 0 && eq[0].at == cyc) begin
            e = eq.pop_front();
            check("done", done, !e.err);
            check("error", error, e.err);
            check("busy_end", busy, 0);
            check("hold_end", cpu_hold, 0);
        end else if (done || error) begin
            check("evt_unexpected", {done, error}, 0);
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
    endtask

    // Good frames carry the two's complement of the header+payload sum, so the inclusive sum is zero.
    task automatic frame(input logic [15:0] addr, input logic [15:0] len, input bit bad);
        logic [7:0] sum;
        logic [9:0] a;
        sum = addr[15:8] + addr[7:0] + len[15:8] + len[7:0];
        a   = addr[9:0];
        send(SYNC);
        check("busy_idle", busy, 0);
        send(addr[15:8]);
        check("busy_start", busy, 1);
        check("hold_start", cpu_hold, 1);
        send(addr[7:0]);
        send(len[15:8]);
        send(len[7:0]);
        for (int i = 0; i < int'(len); i++) begin
            send(pl[i]);
            wq.push_back('{a, pl[i], cyc + 1});
            sum = sum + pl[i];
            a   = a + 10'd1;
        end
        send(bad ? ~(8'h00 - sum) : (8'h00 - sum));
        check("busy_csum", busy, 1);
        eq.push_back('{bad, cyc + 1});
        idle(1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_hold", cpu_hold, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_wr_addr", wr_addr, 0);
        rst = 1'b0;
        #1 check("s_ready", s_ready, 1);

        // Garbage in IDLE, then the basic frame (good and bad checksum).
        send(8'h00);
        send(8'hFF);
        idle(2);
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        frame(16'h0010, 16'd3, 1'b0);
        frame(16'h0010, 16'd3, 1'b1);

        // Zero-length frame.
        frame(16'h0000, 16'd0, 1'b0);

        // Address wrap and dropped upper address bits.
        pl[0] = 8'hAA; pl[1] = 8'hBB;
        frame(16'h03FF, 16'd2, 1'b0);
        pl[0] = 8'hCC;
        frame(16'h1400, 16'd1, 1'b0);

        // SYNC values inside the payload are plain data.
        pl[0] = SYNC; pl[1] = SYNC; pl[2] = 8'h00;
        frame(16'h0100, 16'd3, 1'b0);

        // 256-byte payload exercises the high byte of the length counter and wraps the address.
        for (int i = 0; i < 256; i++) pl[i] = 8'(i) ^ 8'h5A;
        frame(16'h0380, 16'h0100, 1'b0);

        // Stall after ADDR_H: timeout error, then a fresh frame.
        send(SYNC);
        send(8'h12);
        eq.push_back('{1'b1, cyc + 1 + TMO});
        idle(TMO + 4);
        pl[0] = 8'h42;
        frame(16'h0055, 16'd1, 1'b0);

        // Reset mid-DATA: outputs clear at once; already written bytes stay written.
        send(SYNC); send(8'h00); send(8'h20); send(8'h00); send(8'h03);
        send(8'h01);
        wq.push_back('{10'h020, 8'h01, cyc + 1});
        send(8'h02);
        wq.push_back('{10'h021, 8'h02, cyc + 1});
        @(negedge clk);
        s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_wr_en", wr_en, 0);
        check("arst_busy", busy, 0);
        check("arst_hold", cpu_hold, 0);
        check("arst_done", done, 0);
        check("arst_error", error, 0);
        check("arst_wr_data", wr_data, 0);
        idle(2);
        rst = 1'b0;
        #1 check("s_ready_rel", s_ready, 1);
        pl[0] = 8'h10; pl[1] = 8'h20; pl[2] = 8'h30;
        frame(16'h0200, 16'd3, 1'b0);

        idle(5);
        check("wq_drained", wq.size(), 0);
        check("eq_drained", eq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
